keypad_scan_ctrl: RTL

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/keypad_evt_fifo.sv | 43 ++++
 rtl/keypad_scan_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, row drive patterns and the key code table for keypad_scan_ctrl.
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
    localparam logic [3:0] ROW_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // Indexed by {row, col}; '*' reads as E and '#' as F.
    localparam logic [3:0] KEY_CODE [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };
    function automatic logic single_zero(input logic [3:0] s);
        logic [3:0] z;
        z = ~s;
        return z != 4'd0 && (z & (z - 4'd1)) == 4'd0;
    endfunction
    function automatic logic [1:0] zero_col(input logic [3:0] s);
        return !s[0] ? 2'd0 : !s[1] ? 2'd1 : !s[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: key code storage; DEPTH=1 is a single holding register, DEPTH=4 a small FIFO.
module keypad_evt_fifo #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [3:0] i_data,
    input  logic       i_pop,
    output logic [3:0] o_data,
    output logic       o_valid,
    output logic       o_drop
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [3:0]  r_mem [2**PW];
    logic [PW-1:0] r_rd, r_wr;
    logic [PW:0]   r_cnt;
    logic w_pop, w_wr;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign o_valid = r_cnt != '0;
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop && o_valid;
    // A same-cycle pop frees the slot the push needs.
    assign w_wr    = i_push && (r_cnt != (PW+1)'(DEPTH) || w_pop);
    assign o_drop  = i_push && !w_wr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '{default: '0};
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= nxt(r_wr);
            end
            if (w_pop) r_rd <= nxt(r_rd);
            r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with per-tick debounce and key event storage.
// Define KEYPAD_FIFO_EN for a 4-entry key FIFO; otherwise a single holding register is used.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 500000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row_out,
    input  logic [3:0] col_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow,
    input  logic       ovf_clr
);
`ifdef KEYPAD_FIFO_EN
    localparam int FIFO_DEPTH = 4;
`else
    localparam int FIFO_DEPTH = 1;
`endif
    localparam logic [23:0] DIV_LAST = 24'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE_SCANS);
    state_t      r_state;
    logic [3:0]  r_sync1, r_sync2, r_samp, r_cnt;
    logic [23:0] r_div;
    logic [1:0]  r_row;
    logic        r_held, r_ovf;
    logic        w_tick, w_one, w_same, w_idle, w_push, w_drop;
    logic [3:0]  w_cnt_nxt, w_code;
    assign w_tick    = r_div == DIV_LAST;
    assign w_one     = single_zero(r_sync2);
    assign w_same    = r_sync2 == r_samp;
    assign w_idle    = r_sync2 == 4'hF;
    assign w_cnt_nxt = r_cnt + 4'd1;
    assign w_push    = w_tick && ((r_state == SCAN && w_one && DEBOUNCE_SCANS == 1) ||
                                  (r_state == DEBOUNCE && w_same && w_cnt_nxt == DB_LAST));
    assign w_code    = KEY_CODE[{r_row, zero_col(r_sync2)}];
    assign row_out   = ROW_DRIVE[r_row];
    assign key_held  = r_held;
    assign overflow  = r_ovf;
    keypad_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_code),
        .i_pop   (key_ready),
        .o_data  (key_code),
        .o_valid (key_valid),
        .o_drop  (w_drop)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_div   <= '0;
            r_state <= SCAN;
            r_samp  <= 4'hF;
            r_cnt   <= '0;
            r_row   <= '0;
            r_held  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_sync1 <= col_in;
            r_sync2 <= r_sync1;
            r_div   <= w_tick ? '0 : r_div + 24'd1;
            r_ovf   <= w_drop || (r_ovf && !ovf_clr);
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_one) begin
                            r_samp  <= r_sync2;
                            r_cnt   <= 4'd1;
                            r_state <= DEBOUNCE_SCANS == 1 ? HELD : DEBOUNCE;
                            r_held  <= DEBOUNCE_SCANS == 1;
                        end else begin
                            r_row <= r_row + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!w_same) begin
                            r_cnt   <= '0;
                            r_state <= SCAN;
                        end else if (w_cnt_nxt == DB_LAST) begin
                            r_cnt   <= '0;
                            r_state <= HELD;
                            r_held  <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                    HELD: begin
                        if (w_idle) begin
                            r_cnt   <= 4'(DEBOUNCE_SCANS != 1);
                            r_state <= DEBOUNCE_SCANS == 1 ? SCAN : RELEASE;
                            r_held  <= DEBOUNCE_SCANS != 1;
                            if (DEBOUNCE_SCANS == 1) r_row <= r_row + 2'd1;
                        end
                    end
                    RELEASE: begin
                        if (!w_idle) begin
                            r_cnt   <= '0;
                            r_state <= HELD;
                        end else if (w_cnt_nxt == DB_LAST) begin
                            r_cnt   <= '0;
                            r_state <= SCAN;
                            r_held  <= 1'b0;
                            r_row   <= r_row + 2'd1;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                endcase
            end
        end
    end
endmodule
